// File: rtl/sys_pkg.sv
// Shared types for the elevator controller: state encoding, floor index and floor masks,
// plus small mask helpers used by the scheduler and its call latches.
package sys_pkg;

  localparam int NUM_FLOORS = 6;
  localparam int FLOOR_W    = $clog2(NUM_FLOORS);

  typedef logic [2:0] reg3bits;
  typedef logic [NUM_FLOORS-1:0] floor_mask_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    SERVE     = 2'd3
  } E_states;

  function automatic floor_mask_t onehot(reg3bits f);
    floor_mask_t m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i == int'(f));
    return m;
  endfunction

  function automatic floor_mask_t above_mask(reg3bits f);
    floor_mask_t m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic floor_mask_t below_mask(reg3bits f);
    floor_mask_t m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

endpackage

// File: rtl/call_latch.sv
// One pending-call mask: OR-latches requests, drops cleared bits and refuses requests for
// the floor currently being served.
module call_latch
  import sys_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] set_vec,
  input  logic [NUM_FLOORS-1:0] clr_vec,
  input  logic                  absorb,
  input  logic [FLOOR_W-1:0]    absorb_floor,
  output logic [NUM_FLOORS-1:0] pend
);

  logic [NUM_FLOORS-1:0] absorb_mask;

  assign absorb_mask = absorb ? onehot(absorb_floor) : '0;

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend | (set_vec & ~absorb_mask)) & ~clr_vec;
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car SCAN scheduler: latches hall/car calls, sequences the car between floors,
// times travel and door dwell, and drives the motor and door outputs.
module elevator_scheduler
  import sys_pkg::*;
#(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] up_call,
  input  logic [NUM_FLOORS-1:0] down_call,
  input  logic [NUM_FLOORS-1:0] car_call,
  output logic [2:0]            current_floor,
  output E_states               state,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] FLOOR_RELOAD = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_RELOAD  = TW'(DOOR_TICKS - 1);
  localparam floor_mask_t   UP_VALID     = ~(floor_mask_t'(1) << (NUM_FLOORS - 1));
  localparam floor_mask_t   DN_VALID     = ~floor_mask_t'(1);
  localparam reg3bits       TOP_FLOOR    = 3'(NUM_FLOORS - 1);

  logic [TW-1:0] timer;
  floor_mask_t   pend_up, pend_dn, pend_car, all_pend;
  floor_mask_t   up_in, dn_in;
  floor_mask_t   clr_up, clr_dn, clr_car;
  floor_mask_t   cur_oh, nf_oh, serve_oh;
  reg3bits       next_floor, serve_floor;
  logic          here, above, below;
  logic          moving_up, beyond_nf, hall_dir_nf, end_floor, stop, arrive;
  logic          serve_go, serve_dir, serve_beyond, absorb;

  assign up_in    = up_call & UP_VALID;
  assign dn_in    = down_call & DN_VALID;
  assign all_pend = pend_up | pend_dn | pend_car;
  assign pending  = all_pend;

  call_latch u_up (
    .clk(clk), .rst(rst), .set_vec(up_in), .clr_vec(clr_up),
    .absorb(absorb), .absorb_floor(current_floor), .pend(pend_up)
  );

  call_latch u_dn (
    .clk(clk), .rst(rst), .set_vec(dn_in), .clr_vec(clr_dn),
    .absorb(absorb), .absorb_floor(current_floor), .pend(pend_dn)
  );

  call_latch u_car (
    .clk(clk), .rst(rst), .set_vec(car_call), .clr_vec(clr_car),
    .absorb(absorb), .absorb_floor(current_floor), .pend(pend_car)
  );

  always_comb begin
    cur_oh      = onehot(current_floor);
    here        = |(all_pend & cur_oh);
    above       = |(all_pend & above_mask(current_floor));
    below       = |(all_pend & below_mask(current_floor));

    moving_up   = (state == MOVE_UP);
    next_floor  = moving_up ? current_floor + 3'd1 : current_floor - 3'd1;
    nf_oh       = onehot(next_floor);
    beyond_nf   = moving_up ? |(all_pend & above_mask(next_floor))
                            : |(all_pend & below_mask(next_floor));
    hall_dir_nf = moving_up ? |(pend_up & nf_oh) : |(pend_dn & nf_oh);
    end_floor   = moving_up ? (next_floor == TOP_FLOOR) : (next_floor == 3'd0);
    stop        = |(pend_car & nf_oh) | hall_dir_nf | (!beyond_nf & |(all_pend & nf_oh))
                | end_floor;
    arrive      = ((state == MOVE_UP) || (state == MOVE_DOWN)) && (timer == '0);

    serve_go    = ((state == IDLE) && here) || (arrive && stop);
    serve_floor = (state == IDLE) ? current_floor : next_floor;
    serve_oh    = onehot(serve_floor);

    // An idle stop for only the opposite hall call serves it in its own direction;
    // otherwise that call would stay pending at the car's floor and re-trigger SERVE forever.
    if (state == IDLE)
      serve_dir = |((pend_car | (dir_up ? pend_up : pend_dn)) & cur_oh) ? dir_up : !dir_up;
    else
      serve_dir = dir_up;
    serve_beyond = serve_dir ? |(all_pend & above_mask(serve_floor))
                             : |(all_pend & below_mask(serve_floor));

    clr_car = '0;
    clr_up  = '0;
    clr_dn  = '0;
    if (serve_go) begin
      clr_car = serve_oh;
      if (serve_dir || !serve_beyond)  clr_up = serve_oh;
      if (!serve_dir || !serve_beyond) clr_dn = serve_oh;
    end

    absorb = (state == SERVE) && |((up_in | dn_in | car_call) & cur_oh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      current_floor <= '0;
      timer         <= '0;
      dir_up        <= 1'b1;
      motor_up      <= 1'b0;
      motor_down    <= 1'b0;
      door_open     <= 1'b0;
    end else begin
      if (arrive) current_floor <= next_floor;

      if (serve_go) begin
        state      <= SERVE;
        timer      <= DOOR_RELOAD;
        dir_up     <= serve_beyond ? serve_dir : !serve_dir;
        motor_up   <= 1'b0;
        motor_down <= 1'b0;
        door_open  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (above && (dir_up || !below)) begin
              state    <= MOVE_UP;
              dir_up   <= 1'b1;
              timer    <= FLOOR_RELOAD;
              motor_up <= 1'b1;
            end else if (below) begin
              state      <= MOVE_DOWN;
              dir_up     <= 1'b0;
              timer      <= FLOOR_RELOAD;
              motor_down <= 1'b1;
            end
          end
          MOVE_UP, MOVE_DOWN: begin
            if (timer != '0) timer <= timer - 1'b1;
            else             timer <= FLOOR_RELOAD;
          end
          SERVE: begin
            if (absorb)              timer <= DOOR_RELOAD;
            else if (timer != '0)    timer <= timer - 1'b1;
            else begin
              state     <= IDLE;
              door_open <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboarded bench for elevator_scheduler: expected stops (floor, door cycles) are queued
// as calls are placed and checked when the door closes; timing/status checks run inline.
module tb_elevator_scheduler;
  import sys_pkg::*;

  typedef struct {
    int floor;
    int len;
  } stop_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_FLOORS-1:0] up_call = '0;
  logic [NUM_FLOORS-1:0] down_call = '0;
  logic [NUM_FLOORS-1:0] car_call = '0;
  logic [2:0]            current_floor;
  E_states               state;
  logic                  motor_up, motor_down, door_open, dir_up;
  logic [NUM_FLOORS-1:0] pending;

  int    n_cmp = 0;
  int    n_err = 0;
  stop_t exp_q[$];

  logic  door_prev = 1'b0;
  int    door_len = 0;
  int    door_floor = 0;

  elevator_scheduler #(.FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
    .clk(clk), .rst(rst), .up_call(up_call), .down_call(down_call), .car_call(car_call),
    .current_floor(current_floor), .state(state), .motor_up(motor_up),
    .motor_down(motor_down), .door_open(door_open), .dir_up(dir_up), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_FLOORS-1:0] u, input logic [NUM_FLOORS-1:0] d,
                       input logic [NUM_FLOORS-1:0] c);
    up_call = u; down_call = d; car_call = c;
    tick(1);
    up_call = '0; down_call = '0; car_call = '0;
  endtask

  task automatic expect_stop(input int f, input int len);
    stop_t s;
    s.floor = f;
    s.len   = len;
    exp_q.push_back(s);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(state == IDLE && pending == '0 && !door_open) && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(tag, int'(n < budget), 1);
    tick(2);
  endtask

  // Door-open window monitor: a closing door retires the oldest expected stop.
  always @(negedge clk) begin
    stop_t e;
    if (door_open) begin
      if (!door_prev) begin
        door_len   = 0;
        door_floor = int'(current_floor);
      end
      door_len++;
    end else if (door_prev) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_stop", door_floor, -1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_floor", door_floor, e.floor);
        check_eq("sb_door_len", door_len, e.len);
      end
    end
    door_prev = door_open;
  end

  initial begin
    int n;

    tick(1);
    do_reset();
    check_eq("rst_state", int'(state), int'(IDLE));
    check_eq("rst_floor", int'(current_floor), 0);
    check_eq("rst_dir_up", int'(dir_up), 1);
    check_eq("rst_pending", int'(pending), 0);
    check_eq("rst_outputs", int'({motor_up, motor_down, door_open}), 0);

    // Reset while travelling up through floor 2.
    pulse('0, '0, 6'b100000);
    n = 0;
    while (current_floor != 3'd2 && n < 60) begin tick(1); n++; end
    check_eq("t1_reach_floor2", int'(n < 60), 1);
    check_eq("t1_moving", int'(state), int'(MOVE_UP));
    do_reset();
    check_eq("t1_state", int'(state), int'(IDLE));
    check_eq("t1_floor", int'(current_floor), 0);
    check_eq("t1_pending", int'(pending), 0);
    check_eq("t1_outputs", int'({motor_up, motor_down, door_open}), 0);
    tick(3);
    check_eq("t1_stay_idle", int'(state), int'(IDLE));
    check_eq("t1_motor_quiet", int'({motor_up, motor_down}), 0);

    // Single car call from floor 0 to 3.
    expect_stop(3, 3);
    pulse('0, '0, 6'b001000);
    check_eq("t2_latched", int'(pending), 8);
    check_eq("t2_motor_early", int'(motor_up), 0);
    tick(1);
    check_eq("t2_motor_on", int'(motor_up), 1);
    n = 0;
    while (motor_up && n < 50) begin tick(1); n++; end
    check_eq("t2_motor_cycles", n, 12);
    check_eq("t2_floor", int'(current_floor), 3);
    check_eq("t2_serving", int'(state), int'(SERVE));
    wait_idle("t2_idle", 50);
    check_eq("t2_pending", int'(pending), 0);

    // SCAN ordering: up to 2, on to 5, reverse, back to 3.
    do_reset();
    expect_stop(2, 3);
    expect_stop(5, 3);
    expect_stop(3, 3);
    pulse('0, '0, 6'b100000);
    tick(1);
    pulse(6'b000100, '0, '0);
    n = 0;
    while (state != SERVE && n < 40) begin tick(1); n++; end
    check_eq("t3_first_serve", int'(n < 40), 1);
    pulse('0, 6'b001000, '0);
    check_eq("t3_dir_kept_up", int'(dir_up), 1);
    wait_idle("t3_idle", 200);
    check_eq("t3_final_floor", int'(current_floor), 3);
    check_eq("t3_final_dir", int'(dir_up), 1);

    // Idle at 2 heading down: the call below wins, then the call above.
    do_reset();
    expect_stop(2, 3);
    pulse('0, '0, 6'b000100);
    wait_idle("t4_setup_idle", 60);
    check_eq("t4_setup_dir", int'(dir_up), 0);
    expect_stop(1, 3);
    expect_stop(4, 3);
    pulse(6'b010000, 6'b000010, '0);
    tick(1);
    check_eq("t4_down_first", int'(state), int'(MOVE_DOWN));
    check_eq("t4_motor_down", int'(motor_down), 1);
    wait_idle("t4_idle", 200);
    check_eq("t4_final_floor", int'(current_floor), 4);
    check_eq("t4_final_dir", int'(dir_up), 0);

    // Re-request of the serving floor extends the door dwell.
    expect_stop(3, 5);
    pulse('0, '0, 6'b001000);
    n = 0;
    while (!door_open && n < 40) begin tick(1); n++; end
    check_eq("t5_door_opened", int'(n < 40), 1);
    tick(1);
    pulse('0, '0, 6'b001000);
    check_eq("t5_absorbed", int'(pending), 0);
    wait_idle("t5_idle", 50);
    check_eq("t5_pending", int'(pending), 0);

    // Calls with no meaningful direction at the end floors are ignored.
    pulse(6'b100000, 6'b000001, '0);
    check_eq("t6_pending", int'(pending), 0);
    tick(4);
    check_eq("t6_state", int'(state), int'(IDLE));
    check_eq("t6_motors", int'({motor_up, motor_down}), 0);

    tick(2);
    check_eq("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
